// File: rtl/scene_render.sv
// scene_render: 640x480 VGA scene renderer with per-frame shadow snapshot and a 2-stage pixel pipeline.
// The coin layer is built only when SCENE_COIN_DRAW_EN is defined.
module scene_render (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic [1:0]  status,
    input  logic [15:0] score,
    input  logic [15:0] bird_y,
    input  logic [31:0] pipe1,
    input  logic [31:0] pipe2,
    input  logic [31:0] pipe3,
    input  logic [31:0] coin,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        frame_tick
);
    localparam logic [9:0]  H_LAST    = 10'd799;
    localparam logic [9:0]  V_LAST    = 10'd524;
    localparam logic [11:0] C_BIRD_UP = 12'hF80;
    localparam logic [11:0] C_BIRD_DN = 12'hF00;
    localparam logic [11:0] C_PIPE    = 12'h0C0;
    localparam logic [11:0] C_BAR     = 12'hFFF;
    localparam logic [11:0] C_SKY     = 12'h6CF;
`ifdef SCENE_COIN_DRAW_EN
    localparam logic [11:0] C_COIN    = 12'hFF0;
`endif

    function automatic logic [10:0] bar_limit(input logic [15:0] s);
        logic [17:0] w;
        w = {s, 2'b00};
        return (w > 18'd640) ? 11'd640 : w[10:0];
    endfunction

    function automatic logic pipe_hit(input logic [9:0] x, input logic [9:0] y, input logic [27:0] p);
        logic [10:0] left, right, low, high;
        left  = {1'b0, p[19:10]};
        right = left + 11'd50;
        low   = {1'b0, p[9:0]};
        high  = low + {3'b000, p[27:20]};
        return ({1'b0, x} >= left) && ({1'b0, x} <= right) &&
               (({1'b0, y} <= low) || ({1'b0, y} >= high));
    endfunction

    logic [9:0]  hc_q, hc_d, vc_q, vc_d;
    logic [1:0]  sh_status_q, sh_status_d;
    logic [15:0] sh_score_q, sh_score_d;
    logic [10:0] sh_bird_q, sh_bird_d;
    logic [27:0] sh_pipe1_q, sh_pipe1_d, sh_pipe2_q, sh_pipe2_d, sh_pipe3_q, sh_pipe3_d;
    logic        bird_hit_p1_q, bird_hit_p1_d, rising_p1_q, rising_p1_d;
    logic        pipe_hit_p1_q, pipe_hit_p1_d, bar_hit_p1_q, bar_hit_p1_d;
    logic        vis_p1_q, vis_p1_d, hs_p1_q, hs_p1_d, vs_p1_q, vs_p1_d;
    logic [11:0] rgb_p2_q, rgb_p2_d;
    logic        hs_p2_q, hs_p2_d, vs_p2_q, vs_p2_d;
    logic        frame_tick_q, frame_tick_d;
    logic        snap, vis;
    logic [9:0]  gy;
`ifdef SCENE_COIN_DRAW_EN
    logic [20:0] sh_coin_q, sh_coin_d;
    logic        coin_hit_p1_q, coin_hit_p1_d;
`endif

    always_comb begin
        hc_d          = hc_q;
        vc_d          = vc_q;
        sh_status_d   = sh_status_q;
        sh_score_d    = sh_score_q;
        sh_bird_d     = sh_bird_q;
        sh_pipe1_d    = sh_pipe1_q;
        sh_pipe2_d    = sh_pipe2_q;
        sh_pipe3_d    = sh_pipe3_q;
        bird_hit_p1_d = bird_hit_p1_q;
        rising_p1_d   = rising_p1_q;
        pipe_hit_p1_d = pipe_hit_p1_q;
        bar_hit_p1_d  = bar_hit_p1_q;
        vis_p1_d      = vis_p1_q;
        hs_p1_d       = hs_p1_q;
        vs_p1_d       = vs_p1_q;
        rgb_p2_d      = rgb_p2_q;
        hs_p2_d       = hs_p2_q;
        vs_p2_d       = vs_p2_q;
`ifdef SCENE_COIN_DRAW_EN
        sh_coin_d     = sh_coin_q;
        coin_hit_p1_d = coin_hit_p1_q;
`endif
        snap         = pix_en && (hc_q == 10'd0) && (vc_q == 10'd480);
        frame_tick_d = snap;
        vis          = (hc_q < 10'd640) && (vc_q < 10'd480);
        gy           = 10'd479 - vc_q;
        if (pix_en) begin
            hc_d = (hc_q == H_LAST) ? 10'd0 : hc_q + 10'd1;
            if (hc_q == H_LAST) vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
            // Stage 1: hit tests of the current counter position against the shadowed scene.
            vis_p1_d      = vis;
            hs_p1_d       = !((hc_q >= 10'd656) && (hc_q <= 10'd751));
            vs_p1_d       = !((vc_q >= 10'd490) && (vc_q <= 10'd491));
            bird_hit_p1_d = (hc_q >= 10'd40) && (hc_q <= 10'd55) &&
                            ({1'b0, gy} >= {1'b0, sh_bird_q[9:0]}) &&
                            ({1'b0, gy} <= {1'b0, sh_bird_q[9:0]} + 11'd15);
            rising_p1_d   = sh_bird_q[10];
            pipe_hit_p1_d = pipe_hit(hc_q, gy, sh_pipe1_q) || pipe_hit(hc_q, gy, sh_pipe2_q) ||
                            pipe_hit(hc_q, gy, sh_pipe3_q);
            bar_hit_p1_d  = (vc_q < 10'd8) && ({1'b0, hc_q} < bar_limit(sh_score_q));
`ifdef SCENE_COIN_DRAW_EN
            coin_hit_p1_d = sh_coin_q[20] &&
                            ({1'b0, hc_q} >= {1'b0, sh_coin_q[9:0]}) &&
                            ({1'b0, hc_q} <= {1'b0, sh_coin_q[9:0]} + 11'd16) &&
                            ({1'b0, gy} >= {1'b0, sh_coin_q[19:10]}) &&
                            ({1'b0, gy} <= {1'b0, sh_coin_q[19:10]} + 11'd16);
`endif
            // Stage 2: layer priority and blanking, syncs carried alongside.
            hs_p2_d = hs_p1_q;
            vs_p2_d = vs_p1_q;
            if (!vis_p1_q)          rgb_p2_d = 12'h000;
            else if (bird_hit_p1_q) rgb_p2_d = rising_p1_q ? C_BIRD_UP : C_BIRD_DN;
`ifdef SCENE_COIN_DRAW_EN
            else if (coin_hit_p1_q) rgb_p2_d = C_COIN;
`endif
            else if (pipe_hit_p1_q) rgb_p2_d = C_PIPE;
            else if (bar_hit_p1_q)  rgb_p2_d = C_BAR;
            else                    rgb_p2_d = C_SKY;
        end
        if (snap) begin
            sh_status_d = status;
            sh_score_d  = score;
            sh_bird_d   = {bird_y[15], bird_y[9:0]};
            sh_pipe1_d  = pipe1[27:0];
            sh_pipe2_d  = pipe2[27:0];
            sh_pipe3_d  = pipe3[27:0];
`ifdef SCENE_COIN_DRAW_EN
            sh_coin_d   = {coin[31], coin[19:0]};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hc_q          <= '0;
            vc_q          <= '0;
            sh_status_q   <= '0;
            sh_score_q    <= '0;
            sh_bird_q     <= '0;
            sh_pipe1_q    <= '0;
            sh_pipe2_q    <= '0;
            sh_pipe3_q    <= '0;
            bird_hit_p1_q <= 1'b0;
            rising_p1_q   <= 1'b0;
            pipe_hit_p1_q <= 1'b0;
            bar_hit_p1_q  <= 1'b0;
            vis_p1_q      <= 1'b0;
            hs_p1_q       <= 1'b1;
            vs_p1_q       <= 1'b1;
            rgb_p2_q      <= '0;
            hs_p2_q       <= 1'b1;
            vs_p2_q       <= 1'b1;
            frame_tick_q  <= 1'b0;
`ifdef SCENE_COIN_DRAW_EN
            sh_coin_q     <= '0;
            coin_hit_p1_q <= 1'b0;
`endif
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            sh_status_q   <= sh_status_d;
            sh_score_q    <= sh_score_d;
            sh_bird_q     <= sh_bird_d;
            sh_pipe1_q    <= sh_pipe1_d;
            sh_pipe2_q    <= sh_pipe2_d;
            sh_pipe3_q    <= sh_pipe3_d;
            bird_hit_p1_q <= bird_hit_p1_d;
            rising_p1_q   <= rising_p1_d;
            pipe_hit_p1_q <= pipe_hit_p1_d;
            bar_hit_p1_q  <= bar_hit_p1_d;
            vis_p1_q      <= vis_p1_d;
            hs_p1_q       <= hs_p1_d;
            vs_p1_q       <= vs_p1_d;
            rgb_p2_q      <= rgb_p2_d;
            hs_p2_q       <= hs_p2_d;
            vs_p2_q       <= vs_p2_d;
            frame_tick_q  <= frame_tick_d;
`ifdef SCENE_COIN_DRAW_EN
            sh_coin_q     <= sh_coin_d;
            coin_hit_p1_q <= coin_hit_p1_d;
`endif
        end
    end

    assign {red, green, blue} = rgb_p2_q;
    assign hsync              = hs_p2_q;
    assign vsync              = vs_p2_q;
    assign frame_tick         = frame_tick_q;

    // Game mode is latched with the scene but never drawn; ignored input fields end here.
    logic unused_inputs;
`ifdef SCENE_COIN_DRAW_EN
    assign unused_inputs = ^{sh_status_q, bird_y[14:10], pipe1[31:28], pipe2[31:28], pipe3[31:28], coin[30:20]};
`else
    assign unused_inputs = ^{sh_status_q, bird_y[14:10], pipe1[31:28], pipe2[31:28], pipe3[31:28], coin};
`endif
endmodule

// File: tb/tb_scene_render.sv
// tb_scene_render: randomized-stimulus bench for scene_render with a frame-level behavioural model.
`timescale 1ns/1ps
module tb_scene_render;
    logic        clk = 1'b0;
    logic        rst, pix_en;
    logic [1:0]  status;
    logic [15:0] score, bird_y;
    logic [31:0] pipe1, pipe2, pipe3, coin;
    logic        hsync, vsync, frame_tick;
    logic [3:0]  red, green, blue;

    always #5 clk = ~clk;

    scene_render dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .status(status), .score(score),
        .bird_y(bird_y), .pipe1(pipe1), .pipe2(pipe2), .pipe3(pipe3), .coin(coin),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
        .frame_tick(frame_tick)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (pix tick %0d, t=%0t)", name, got, want, m_tick, $time);
            if (n_fail >= 40) begin
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
                $finish;
            end
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        int          x;
        int          v;
        int          epoch;
    } pix_t;

    pix_t        hist[$];
    int          m_tick   = 0;
    int          m_snaps  = 0;
    int          lit_base = 0;
    logic        m_ft     = 1'b0;
    logic        m_new    = 1'b0;
    logic        m_in_rst = 1'b0;
    logic        started  = 1'b0;
    logic [15:0] s_score, s_bird;
    logic [31:0] s_pipe[3];
    logic [31:0] s_coin;

    function automatic logic [11:0] ref_rgb(input int x, input int v);
        int y, by, px, py, g, lim;
        if (x >= 640 || v >= 480) return 12'h000;
        y  = 479 - v;
        by = int'(s_bird[9:0]);
        if (x >= 40 && x <= 55 && y >= by && y <= by + 15) return s_bird[15] ? 12'hF80 : 12'hF00;
`ifdef SCENE_COIN_DRAW_EN
        begin
            int cx, cy;
            cx = int'(s_coin[9:0]);
            cy = int'(s_coin[19:10]);
            if (s_coin[31] && x >= cx && x <= cx + 16 && y >= cy && y <= cy + 16) return 12'hFF0;
        end
`endif
        for (int i = 0; i < 3; i++) begin
            px = int'(s_pipe[i][19:10]);
            py = int'(s_pipe[i][9:0]);
            g  = int'(s_pipe[i][27:20]);
            if (x >= px && x <= px + 50 && (y <= py || y >= py + g)) return 12'h0C0;
        end
        lim = int'(s_score) * 4;
        if (lim > 640) lim = 640;
        if (v < 8 && x < lim) return 12'hFFF;
        return 12'h6CF;
    endfunction

    always @(posedge clk) begin
        pix_t p;
        int   x, v;
        m_ft  = 1'b0;
        m_new = 1'b0;
        m_in_rst = rst;
        if (rst) begin
            started = 1'b1;
            m_tick  = 0;
            m_snaps = 0;
            s_score = '0;
            s_bird  = '0;
            s_coin  = '0;
            for (int i = 0; i < 3; i++) s_pipe[i] = '0;
            hist.delete();
        end else if (pix_en) begin
            x = m_tick % 800;
            v = (m_tick / 800) % 525;
            p.rgb   = ref_rgb(x, v);
            p.hs    = !(x >= 656 && x <= 751);
            p.vs    = !(v >= 490 && v <= 491);
            p.x     = x;
            p.v     = v;
            p.epoch = lit_base + m_snaps;
            hist.push_back(p);
            if (hist.size() > 2) void'(hist.pop_front());
            if (x == 0 && v == 480) begin
                m_ft     = 1'b1;
                s_score  = score;
                s_bird   = bird_y;
                s_pipe[0] = pipe1;
                s_pipe[1] = pipe2;
                s_pipe[2] = pipe3;
                s_coin   = coin;
                m_snaps++;
            end
            m_tick++;
            m_new = 1'b1;
        end
    end

    // ---------------- hand-computed anchor pixels ----------------
    localparam int NLIT = 21;
`ifdef SCENE_COIN_DRAW_EN
    localparam logic [11:0] C_COINPIX = 12'hFF0;
`else
    localparam logic [11:0] C_COINPIX = 12'h0C0;
`endif
    int lit_e [NLIT] = '{0, 0, 0,
                         1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1,
                         2, 2, 2, 2, 2,
                         100, 100};
    int lit_x [NLIT] = '{0, 60, 45,
                         45, 45, 120, 120, 120, 120, 151, 305, 39, 40, 410,
                         45, 120, 410, 599, 120,
                         0, 60};
    int lit_v [NLIT] = '{0, 0, 479,
                         279, 200, 329, 328, 230, 229, 329, 174, 3, 3, 200,
                         279, 150, 200, 7, 3,
                         0, 0};
    logic [11:0] lit_c [NLIT] = '{12'h0C0, 12'h6CF, 12'hF00,
                                  12'hF80, 12'h6CF, 12'h0C0, 12'h6CF, 12'h6CF, 12'h0C0, 12'h6CF,
                                  C_COINPIX, 12'hFFF, 12'h6CF, 12'h6CF,
                                  12'hF00, 12'h6CF, 12'h0C0, 12'hFFF, 12'hFFF,
                                  12'h0C0, 12'h6CF};
    int lit_seen = 0;

    // ---------------- compare process ----------------
    logic prev_hs = 1'b1, prev_vs = 1'b1;
    logic have_hf = 1'b0, have_vf = 1'b0;
    int   hf_t = 0, vf_t = 0, ft_cnt = 0;

    always @(negedge clk) begin
        logic [11:0] e_rgb;
        logic        e_hs, e_vs;
        if (started) begin
            e_rgb = 12'h000;
            e_hs  = 1'b1;
            e_vs  = 1'b1;
            if (hist.size() == 2) begin
                e_rgb = hist[0].rgb;
                e_hs  = hist[0].hs;
                e_vs  = hist[0].vs;
            end
            check("pixel_rgb_sync", {18'd0, red, green, blue, hsync, vsync}, {18'd0, e_rgb, e_hs, e_vs});
            check("frame_tick", {31'd0, frame_tick}, {31'd0, m_ft});
            if (m_new && hist.size() == 2) begin
                for (int i = 0; i < NLIT; i++) begin
                    if (hist[0].epoch == lit_e[i] && hist[0].x == lit_x[i] && hist[0].v == lit_v[i]) begin
                        lit_seen++;
                        check($sformatf("anchor_e%0d_x%0d_v%0d", lit_e[i], lit_x[i], lit_v[i]),
                              {20'd0, red, green, blue}, {20'd0, lit_c[i]});
                    end
                end
            end
            if (m_in_rst) begin
                have_hf = 1'b0;
                have_vf = 1'b0;
                ft_cnt  = 0;
            end else begin
                if (frame_tick) ft_cnt++;
                if (prev_hs && !hsync) begin
                    if (have_hf) check("hsync_period", m_tick - hf_t, 800);
                    hf_t    = m_tick;
                    have_hf = 1'b1;
                end
                if (!prev_hs && hsync && have_hf) check("hsync_low", m_tick - hf_t, 96);
                if (prev_vs && !vsync) begin
                    if (have_vf) begin
                        check("vsync_period", m_tick - vf_t, 420000);
                        check("frame_ticks_per_frame", ft_cnt, 1);
                    end
                    vf_t    = m_tick;
                    have_vf = 1'b1;
                    ft_cnt  = 0;
                end
                if (!prev_vs && vsync && have_vf) check("vsync_low", m_tick - vf_t, 1600);
            end
            prev_hs = hsync;
            prev_vs = vsync;
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_until(input int snaps, input int hc, input int vc, input int budget, input string tag);
        int n;
        n = 0;
        while (!(m_snaps >= snaps && (m_tick % 800) == hc && ((m_tick / 800) % 525) == vc) && n < budget) begin
            @(negedge clk);
            pix_en = ($urandom_range(0, 15) != 0);
            n++;
        end
        if (n >= budget) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout_%s: got tick %0d want position hc=%0d vc=%0d", tag, m_tick, hc, vc);
        end
    endtask

    initial begin
        rst    = 1'b1;
        pix_en = 1'b0;
        status = 2'($urandom);
        score  = 16'd10;
        bird_y = {1'b1, 5'($urandom), 10'd200};
        pipe1  = {4'($urandom), 8'd100, 10'd100, 10'd150};
        pipe2  = {4'($urandom), 8'd120, 10'd290, 10'd100};
        pipe3  = {4'($urandom), 8'($urandom), 10'd600, 10'($urandom_range(0, 400))};
        coin   = {1'b1, 11'($urandom), 10'd300, 10'd300};
        repeat (2) @(negedge clk);
        pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4 * 2400; k++) begin
            @(negedge clk);
            pix_en = ((k % 4) == 3);
        end
        run_until(1, 0, 100, 900000, "frame2_vc100");
        status = 2'($urandom);
        score  = 16'd200;
        bird_y = {1'b0, 5'($urandom), 10'd200};
        pipe1  = {4'($urandom), 8'd60, 10'd400, 10'd50};
        run_until(2, 0, 300, 900000, "frame3_vc300");
        lit_base = 100;
        rst      = 1'b1;
        pix_en   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_black_sync_high", {18'd0, red, green, blue, hsync, vsync}, {18'd0, 12'h000, 2'b11});
        check("post_rst_frame_tick", {31'd0, frame_tick}, 32'd0);
        run_until(0, 0, 3, 20000, "post_rst_lines");
        repeat (8) @(negedge clk);
        check("anchors_reached", lit_seen, NLIT);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
